// File: rtl/cond_flag_unit_pkg.sv
// ---------------------------------------------------------------------------
// pda_cond_pkg : condition codes, NZCV flag struct and flag bit positions
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pda_cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ  = 4'h0,
    COND_NE  = 4'h1,
    COND_CS  = 4'h2,
    COND_CC  = 4'h3,
    COND_MI  = 4'h4,
    COND_PL  = 4'h5,
    COND_VS  = 4'h6,
    COND_VC  = 4'h7,
    COND_HI  = 4'h8,
    COND_LS  = 4'h9,
    COND_GE  = 4'hA,
    COND_LT  = 4'hB,
    COND_GT  = 4'hC,
    COND_LE  = 4'hD,
    COND_AL  = 4'hE,
    COND_RSV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/cond_flag_unit_if.sv
// ---------------------------------------------------------------------------
// cond_flag_unit_if : decoder-side bundle of the conditional unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cond_flag_unit_if #(
  parameter int NUM_CTX = 1,
  parameter int CNT_W   = 16
);
  localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

  logic             valid_i;
  logic             stall_i;
  logic [CTX_W-1:0] ctx_i;
  logic [3:0]       cond_i;
  logic [3:0]       alu_flags_i;
  logic [1:0]       flag_w_i;
  logic             pcs_i;
  logic             reg_w_i;
  logic             mem_w_i;
  logic             no_write_i;
  logic             clr_cnt_i;
  logic             pc_src_o;
  logic             reg_write_o;
  logic             mem_write_o;
  logic             cond_ex_o;
  logic             cond_ex_q_o;
  logic [3:0]       flags_o;
  logic [CNT_W-1:0] skip_cnt_o;

  modport master (
    output valid_i, stall_i, ctx_i, cond_i, alu_flags_i, flag_w_i,
           pcs_i, reg_w_i, mem_w_i, no_write_i, clr_cnt_i,
    input  pc_src_o, reg_write_o, mem_write_o, cond_ex_o, cond_ex_q_o,
           flags_o, skip_cnt_o
  );

  modport slave (
    input  valid_i, stall_i, ctx_i, cond_i, alu_flags_i, flag_w_i,
           pcs_i, reg_w_i, mem_w_i, no_write_i, clr_cnt_i,
    output pc_src_o, reg_write_o, mem_write_o, cond_ex_o, cond_ex_q_o,
           flags_o, skip_cnt_o
  );

endinterface

`default_nettype wire

// File: rtl/cond_flag_unit_cond_check.sv
// ---------------------------------------------------------------------------
// cond_check : combinational evaluation of a 4-bit condition against NZCV
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cond_check
  import pda_cond_pkg::*;
(
  input  cond_e  cond_i,
  input  flags_t flags_i,
  output logic   pass_o
);

  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      COND_EQ:  pass_o = flags_i.z;
      COND_NE:  pass_o = ~flags_i.z;
      COND_CS:  pass_o = flags_i.c;
      COND_CC:  pass_o = ~flags_i.c;
      COND_MI:  pass_o = flags_i.n;
      COND_PL:  pass_o = ~flags_i.n;
      COND_VS:  pass_o = flags_i.v;
      COND_VC:  pass_o = ~flags_i.v;
      COND_HI:  pass_o = flags_i.c & ~flags_i.z;
      COND_LS:  pass_o = ~flags_i.c | flags_i.z;
      COND_GE:  pass_o = (flags_i.n == flags_i.v);
      COND_LT:  pass_o = (flags_i.n != flags_i.v);
      COND_GT:  pass_o = ~flags_i.z & (flags_i.n == flags_i.v);
      COND_LE:  pass_o = flags_i.z | (flags_i.n != flags_i.v);
      COND_AL:  pass_o = 1'b1;
      COND_RSV: pass_o = 1'b0;
      default:  pass_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cond_flag_unit.sv
// ---------------------------------------------------------------------------
// cond_flag_unit : per-context NZCV flags, condition gating of PC/reg/mem
//                  writes; optional skip counter when SKIP_CNT_EN is defined
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cond_flag_unit
  import pda_cond_pkg::*;
#(
  parameter int NUM_CTX = 1,
  parameter int CNT_W   = 16
) (
  input  wire             clk,
  input  wire             reset,
  cond_flag_unit_if.slave bus
);

  localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

  flags_t flags_q [NUM_CTX];
  flags_t flags_d [NUM_CTX];
  flags_t sel_flags;
  logic   ctx_ok;
  logic   act;
  logic   cond_pass;
  logic   cond_ex;
  logic   cond_ex_q_q;
  logic   cond_ex_q_d;

  // Only the registered flags of the addressed context feed the condition check
  always_comb begin
    sel_flags = '0;
    ctx_ok    = 1'b0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (bus.ctx_i == CTX_W'(i)) begin
        sel_flags = flags_q[i];
        ctx_ok    = 1'b1;
      end
    end
  end

  assign act = bus.valid_i & ~bus.stall_i & ctx_ok;

  cond_check u_cond_check (
    .cond_i  (cond_e'(bus.cond_i)),
    .flags_i (sel_flags),
    .pass_o  (cond_pass)
  );

  assign cond_ex         = act & cond_pass;
  assign bus.cond_ex_o   = cond_ex;
  assign bus.pc_src_o    = cond_ex & bus.pcs_i;
  assign bus.reg_write_o = cond_ex & bus.reg_w_i & ~bus.no_write_i;
  assign bus.mem_write_o = cond_ex & bus.mem_w_i;
  assign bus.flags_o     = sel_flags;
  assign bus.cond_ex_q_o = cond_ex_q_q;

  always_comb begin
    for (int i = 0; i < NUM_CTX; i++) begin
      flags_d[i] = flags_q[i];
      if (cond_ex && (bus.ctx_i == CTX_W'(i))) begin
        if (bus.flag_w_i[1]) begin
          flags_d[i].n = bus.alu_flags_i[FLAG_N];
          flags_d[i].z = bus.alu_flags_i[FLAG_Z];
        end
        if (bus.flag_w_i[0]) begin
          flags_d[i].c = bus.alu_flags_i[FLAG_C];
          flags_d[i].v = bus.alu_flags_i[FLAG_V];
        end
      end
    end
  end

  assign cond_ex_q_d = bus.stall_i ? cond_ex_q_q : cond_ex;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        flags_q[i] <= '0;
      end
      cond_ex_q_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        flags_q[i] <= flags_d[i];
      end
      cond_ex_q_q <= cond_ex_q_d;
    end
  end

`ifdef SKIP_CNT_EN
  logic [CNT_W-1:0] skip_cnt_q;
  logic [CNT_W-1:0] skip_cnt_d;

  // Clear beats increment and is honoured even while stalled
  always_comb begin
    skip_cnt_d = skip_cnt_q;
    if (bus.clr_cnt_i) begin
      skip_cnt_d = '0;
    end else if (act && !cond_pass && !(&skip_cnt_q)) begin
      skip_cnt_d = skip_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip_cnt_q <= '0;
    end else begin
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign bus.skip_cnt_o = skip_cnt_q;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = bus.clr_cnt_i;
  assign bus.skip_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_cond_flag_unit : directed self-checking bench for cond_flag_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cond_flag_unit;

  localparam int NUM_CTX = 3;
  localparam int CNT_W   = 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  cond_flag_unit_if #(.NUM_CTX(NUM_CTX), .CNT_W(CNT_W)) bus ();

  cond_flag_unit #(.NUM_CTX(NUM_CTX), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change one time unit after the active edge; checks follow a further unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [1:0] ctx, input logic [3:0] cond,
                       input logic [1:0] fw, input logic [3:0] alu);
    bus.valid_i     = 1'b1;
    bus.ctx_i       = ctx;
    bus.cond_i      = cond;
    bus.flag_w_i    = fw;
    bus.alu_flags_i = alu;
  endtask

  task automatic idle();
    bus.valid_i  = 1'b0;
    bus.flag_w_i = 2'b00;
    bus.pcs_i    = 1'b0;
    bus.reg_w_i  = 1'b0;
    bus.mem_w_i  = 1'b0;
    bus.no_write_i = 1'b0;
    bus.stall_i  = 1'b0;
    bus.clr_cnt_i = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    idle();
    bus.ctx_i       = '0;
    bus.cond_i      = 4'h0;
    bus.alu_flags_i = 4'h0;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_flags", 32'(bus.flags_o), 32'h0);
    check("rst_cexq", 32'(bus.cond_ex_q_o), 32'h0);
    check("rst_cnt", 32'(bus.skip_cnt_o), 32'h0);

    // Load 1111 then hit asynchronous reset mid-cycle
    step();
    instr(2'd0, 4'hE, 2'b11, 4'hF);
    step();
    idle();
    #1;
    check("pre_rst_flags", 32'(bus.flags_o), 32'hF);
    check("pre_rst_cexq", 32'(bus.cond_ex_q_o), 32'h1);
    reset = 1'b1;
    #1;
    check("async_rst_flags", 32'(bus.flags_o), 32'h0);
    check("async_rst_cexq", 32'(bus.cond_ex_q_o), 32'h0);
    check("async_rst_cnt", 32'(bus.skip_cnt_o), 32'h0);
    step();
    reset = 1'b0;

    // Write Z via AL, then EQ/NE against it
    step();
    instr(2'd0, 4'hE, 2'b11, 4'h4);
    #1;
    check("al_cex", 32'(bus.cond_ex_o), 32'h1);
    step();
    bus.flag_w_i = 2'b00;
    bus.cond_i = 4'h0;
    #1;
    check("flags_0100", 32'(bus.flags_o), 32'h4);
    check("eq_pass", 32'(bus.cond_ex_o), 32'h1);
    bus.cond_i = 4'h1;
    #1;
    check("ne_fail", 32'(bus.cond_ex_o), 32'h0);

    // Signed comparisons on 1001 and 1100
    instr(2'd0, 4'hE, 2'b11, 4'h9);
    step();
    instr(2'd0, 4'hA, 2'b00, 4'h0);
    #1;
    check("ge_1001", 32'(bus.cond_ex_o), 32'h1);
    bus.cond_i = 4'hC;
    #1;
    check("gt_1001", 32'(bus.cond_ex_o), 32'h1);
    bus.cond_i = 4'hB;
    #1;
    check("lt_1001", 32'(bus.cond_ex_o), 32'h0);
    bus.cond_i = 4'hF;
    #1;
    check("rsv_1001", 32'(bus.cond_ex_o), 32'h0);
    instr(2'd0, 4'hE, 2'b11, 4'hC);
    step();
    instr(2'd0, 4'hD, 2'b00, 4'h0);
    #1;
    check("le_1100", 32'(bus.cond_ex_o), 32'h1);
    bus.cond_i = 4'h8;
    #1;
    check("hi_1100", 32'(bus.cond_ex_o), 32'h0);
    bus.cond_i = 4'hF;
    #1;
    check("rsv_1100", 32'(bus.cond_ex_o), 32'h0);

    // Context isolation and out-of-range context
    instr(2'd2, 4'hE, 2'b11, 4'h2);
    step();
    instr(2'd0, 4'h2, 2'b00, 4'h0);
    #1;
    check("ctx0_cs", 32'(bus.cond_ex_o), 32'h0);
    bus.ctx_i = 2'd2;
    #1;
    check("ctx2_cs", 32'(bus.cond_ex_o), 32'h1);
    check("ctx2_flags", 32'(bus.flags_o), 32'h2);
    instr(2'd3, 4'hE, 2'b11, 4'hF);
    bus.pcs_i = 1'b1;
    #1;
    check("oor_cex", 32'(bus.cond_ex_o), 32'h0);
    check("oor_pcsrc", 32'(bus.pc_src_o), 32'h0);
    step();
    idle();
    bus.ctx_i = 2'd0;
    #1;
    check("oor_ctx0_kept", 32'(bus.flags_o), 32'hC);
    bus.ctx_i = 2'd2;
    #1;
    check("oor_ctx2_kept", 32'(bus.flags_o), 32'h2);

    // Failed condition gates everything; no_write gates reg only
    instr(2'd0, 4'h1, 2'b11, 4'h3);
    bus.pcs_i = 1'b1;
    bus.reg_w_i = 1'b1;
    bus.mem_w_i = 1'b1;
    #1;
    check("fail_pcsrc", 32'(bus.pc_src_o), 32'h0);
    check("fail_regw", 32'(bus.reg_write_o), 32'h0);
    check("fail_memw", 32'(bus.mem_write_o), 32'h0);
    step();
    check("fail_flags_kept", 32'(bus.flags_o), 32'hC);
    instr(2'd0, 4'h0, 2'b00, 4'h0);
    bus.no_write_i = 1'b1;
    #1;
    check("nw_regw", 32'(bus.reg_write_o), 32'h0);
    check("nw_memw", 32'(bus.mem_write_o), 32'h1);
    check("nw_pcsrc", 32'(bus.pc_src_o), 32'h1);
    step();
    check("cexq_set", 32'(bus.cond_ex_q_o), 32'h1);

    // Stall: no gating, no flag write, cond_ex_q holds
    instr(2'd0, 4'h0, 2'b11, 4'h0);
    bus.stall_i = 1'b1;
    #1;
    check("stall_cex", 32'(bus.cond_ex_o), 32'h0);
    check("stall_memw", 32'(bus.mem_write_o), 32'h0);
    step();
    check("stall_cexq_hold", 32'(bus.cond_ex_q_o), 32'h1);
    check("stall_flags_kept", 32'(bus.flags_o), 32'hC);
    idle();
    instr(2'd0, 4'hF, 2'b00, 4'h0);
    step();
    check("cexq_clr", 32'(bus.cond_ex_q_o), 32'h0);

`ifdef SKIP_CNT_EN
    idle();
    bus.clr_cnt_i = 1'b1;
    step();
    bus.clr_cnt_i = 1'b0;
    check("cnt_cleared", 32'(bus.skip_cnt_o), 32'h0);
    instr(2'd0, 4'hF, 2'b00, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("cnt_%0d", i), 32'(bus.skip_cnt_o), (i < 3) ? 32'(i + 1) : 32'h3);
    end
    bus.stall_i = 1'b1;
    bus.ctx_i = 2'd0;
    step();
    check("cnt_stall_hold", 32'(bus.skip_cnt_o), 32'h3);
    bus.stall_i = 1'b0;
    bus.clr_cnt_i = 1'b1;
    step();
    check("cnt_clr_wins", 32'(bus.skip_cnt_o), 32'h0);
`else
    instr(2'd0, 4'hF, 2'b00, 4'h0);
    bus.clr_cnt_i = 1'b0;
    step();
    step();
    check("cnt_absent", 32'(bus.skip_cnt_o), 32'h0);
`endif

    idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
